// File: rtl/cpu_pkg.sv
// Shared types and constants for the Simple RISC Machine controller:
// state encoding, opcode/op values, writeback selects and IR field positions.
package cpu_pkg;

    typedef enum logic [2:0] {
        S_WAIT,
        S_DECODE,
        S_GET_A,
        S_GET_B,
        S_EXEC,
        S_WR_IMM,
        S_WR_REG
    } state_t;

    typedef enum logic [2:0] {
        C_MOV_IMM,
        C_MOV_REG,
        C_ALU,
        C_CMP,
        C_MVN,
        C_ILLEGAL
    } iclass_t;

    localparam logic [2:0] OPC_MOV    = 3'b110;
    localparam logic [2:0] OPC_ALU    = 3'b101;
    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_ADD     = 2'b00;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_AND     = 2'b10;
    localparam logic [1:0] OP_MVN     = 2'b11;

    localparam logic [1:0] VSEL_C   = 2'b00;
    localparam logic [1:0] VSEL_IMM = 2'b10;

    localparam int OPC_MSB = 15, OPC_LSB = 13;
    localparam int OP_MSB  = 12, OP_LSB  = 11;
    localparam int RN_MSB  = 10, RN_LSB  = 8;
    localparam int RD_MSB  = 7,  RD_LSB  = 5;
    localparam int SH_MSB  = 4,  SH_LSB  = 3;
    localparam int RM_MSB  = 2,  RM_LSB  = 0;
    localparam int IMM_MSB = 7;

    // Everything the FSM drives, registered together as one word.
    typedef struct packed {
        logic       w;
        logic [2:0] readnum;
        logic [2:0] writenum;
        logic       write;
        logic       loada;
        logic       loadb;
        logic       loadc;
        logic       loads;
        logic       asel;
        logic [1:0] vsel;
        logic [1:0] shift;
        logic [1:0] aluop;
        logic       illegal;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '{w: 1'b1, default: '0};

    function automatic logic [15:0] sext8(input logic [7:0] v);
        return {{8{v[IMM_MSB]}}, v};
    endfunction

endpackage

// File: rtl/instr_dec.sv
// Combinational instruction decoder: splits the IR into fields, sign-extends
// the 8-bit immediate and classifies the instruction.
module instr_dec
    import cpu_pkg::*;
(
    input  logic [15:0] ir,
    output logic [1:0]  op,
    output logic [2:0]  rn,
    output logic [2:0]  rd,
    output logic [1:0]  sh,
    output logic [2:0]  rm,
    output logic [15:0] sximm8,
    output iclass_t     cls
);

    logic [2:0] opcode;

    assign opcode = ir[OPC_MSB:OPC_LSB];
    assign op     = ir[OP_MSB:OP_LSB];
    assign rn     = ir[RN_MSB:RN_LSB];
    assign rd     = ir[RD_MSB:RD_LSB];
    assign sh     = ir[SH_MSB:SH_LSB];
    assign rm     = ir[RM_MSB:RM_LSB];
    assign sximm8 = sext8(ir[7:0]);

    always_comb begin
        cls = C_ILLEGAL;
        if (opcode == OPC_MOV) begin
            if (op == OP_MOV_IMM)      cls = C_MOV_IMM;
            else if (op == OP_MOV_REG) cls = C_MOV_REG;
        end else if (opcode == OPC_ALU) begin
            case (op)
                OP_ADD, OP_AND: cls = C_ALU;
                OP_CMP:         cls = C_CMP;
                OP_MVN:         cls = C_MVN;
                default:        cls = C_ILLEGAL;
            endcase
        end
    end

endmodule

// File: rtl/cpu_ctrl.sv
// Instruction register plus multi-cycle control FSM for the Simple RISC Machine.
// Outputs are registered from the next state so they line up with the state.
module cpu_ctrl
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] in,
    input  logic        load,
    input  logic        s,
    output logic        w,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic        write,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        asel,
    output logic [1:0]  vsel,
    output logic [1:0]  shift,
    output logic [1:0]  aluop,
    output logic [15:0] sximm8,
    output logic        illegal
);

    state_t      state, state_nxt;
    ctrl_t       ctrl, ctrl_nxt;
    logic [15:0] ir, ir_nxt;
    logic [15:0] sximm8_r;

    logic [1:0]  d_op, d_sh;
    logic [2:0]  d_rn, d_rd, d_rm;
    logic [15:0] d_sximm8;
    iclass_t     d_cls;

    // IR only accepts a new word while idle.
    assign ir_nxt = (state == S_WAIT && load) ? in : ir;

    // Decoding ir_nxt lets DECODE see a word loaded on the same edge as s.
    instr_dec u_dec (
        .ir     (ir_nxt),
        .op     (d_op),
        .rn     (d_rn),
        .rd     (d_rd),
        .sh     (d_sh),
        .rm     (d_rm),
        .sximm8 (d_sximm8),
        .cls    (d_cls)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            S_WAIT:   if (s) state_nxt = S_DECODE;
            S_DECODE: begin
                case (d_cls)
                    C_MOV_IMM:        state_nxt = S_WR_IMM;
                    C_MOV_REG, C_MVN: state_nxt = S_GET_B;
                    C_ALU, C_CMP:     state_nxt = S_GET_A;
                    default:          state_nxt = S_WAIT;
                endcase
            end
            S_GET_A:  state_nxt = S_GET_B;
            S_GET_B:  state_nxt = S_EXEC;
            S_EXEC:   state_nxt = (d_cls == C_CMP) ? S_WAIT : S_WR_REG;
            default:  state_nxt = S_WAIT;
        endcase
    end

    always_comb begin
        ctrl_nxt = '0;
        case (state_nxt)
            S_WAIT:   ctrl_nxt.w = 1'b1;
            S_DECODE: ctrl_nxt.illegal = (d_cls == C_ILLEGAL);
            S_GET_A: begin
                ctrl_nxt.readnum = d_rn;
                ctrl_nxt.loada   = 1'b1;
            end
            S_GET_B: begin
                ctrl_nxt.readnum = d_rm;
                ctrl_nxt.loadb   = 1'b1;
            end
            S_EXEC: begin
                ctrl_nxt.shift = d_sh;
                // MOV reg runs as 0 + shifted Rm.
                ctrl_nxt.aluop = (d_cls == C_MOV_REG) ? 2'b00 : d_op;
                ctrl_nxt.asel  = (d_cls == C_MOV_REG);
                ctrl_nxt.loads = (d_cls == C_CMP);
                ctrl_nxt.loadc = (d_cls != C_CMP);
            end
            S_WR_IMM: begin
                ctrl_nxt.writenum = d_rn;
                ctrl_nxt.write    = 1'b1;
                ctrl_nxt.vsel     = VSEL_IMM;
            end
            S_WR_REG: begin
                ctrl_nxt.writenum = d_rd;
                ctrl_nxt.write    = 1'b1;
                ctrl_nxt.vsel     = VSEL_C;
            end
            default: ctrl_nxt = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_WAIT;
            ir       <= '0;
            ctrl     <= CTRL_IDLE;
            sximm8_r <= '0;
        end else begin
            state    <= state_nxt;
            ir       <= ir_nxt;
            ctrl     <= ctrl_nxt;
            sximm8_r <= d_sximm8;
        end
    end

    assign w        = ctrl.w;
    assign readnum  = ctrl.readnum;
    assign writenum = ctrl.writenum;
    assign write    = ctrl.write;
    assign loada    = ctrl.loada;
    assign loadb    = ctrl.loadb;
    assign loadc    = ctrl.loadc;
    assign loads    = ctrl.loads;
    assign asel     = ctrl.asel;
    assign vsel     = ctrl.vsel;
    assign shift    = ctrl.shift;
    assign aluop    = ctrl.aluop;
    assign illegal  = ctrl.illegal;
    assign sximm8   = sximm8_r;

endmodule

// File: tb/tb_cpu_ctrl.sv
// Directed plus randomized checks of cpu_ctrl against a per-instruction
// phase-table model of the control sequence.
module tb_cpu_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] in;
    logic        load, s;
    logic        w, write, loada, loadb, loadc, loads, asel, illegal;
    logic [2:0]  readnum, writenum;
    logic [1:0]  vsel, shift, aluop;
    logic [15:0] sximm8;

    localparam int P_WAIT = 0, P_DEC = 1, P_A = 2, P_B = 3, P_EX = 4, P_WI = 5, P_WR = 6;

    int n_cmp = 0;
    int n_bad = 0;
    int phases[$];
    logic [35:0] obs;
    logic [35:0] rst_vec;

    cpu_ctrl dut (
        .clk(clk), .rst_n(rst_n), .in(in), .load(load), .s(s), .w(w),
        .readnum(readnum), .writenum(writenum), .write(write),
        .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
        .asel(asel), .vsel(vsel), .shift(shift), .aluop(aluop),
        .sximm8(sximm8), .illegal(illegal)
    );

    always #5 clk = ~clk;

    assign obs = {w, readnum, writenum, write, loada, loadb, loadc, loads,
                  asel, vsel, shift, aluop, illegal, sximm8};

    // Expected outputs in a given phase of executing instruction ir.
    function automatic logic [35:0] expect_vec(input int ph, input logic [15:0] ir);
        logic       e_w, e_wr, e_la, e_lb, e_lc, e_ls, e_as, e_il;
        logic [2:0] e_rn, e_wn;
        logic [1:0] e_vs, e_sh, e_al;
        logic       mov_reg, is_cmp;
        mov_reg = (ir[15:11] == 5'b11000);
        is_cmp  = (ir[15:11] == 5'b10101);
        {e_w, e_wr, e_la, e_lb, e_lc, e_ls, e_as, e_il} = '0;
        {e_rn, e_wn, e_vs, e_sh, e_al} = '0;
        case (ph)
            P_WAIT: e_w = 1'b1;
            P_DEC:  e_il = !(ir[15:11] inside {5'b11010, 5'b11000, 5'b10100,
                                               5'b10101, 5'b10110, 5'b10111});
            P_A:    begin e_rn = ir[10:8]; e_la = 1'b1; end
            P_B:    begin e_rn = ir[2:0];  e_lb = 1'b1; end
            P_EX:   begin
                e_sh = ir[4:3];
                e_al = mov_reg ? 2'b00 : ir[12:11];
                e_as = mov_reg;
                e_ls = is_cmp;
                e_lc = !is_cmp;
            end
            P_WI:   begin e_wn = ir[10:8]; e_wr = 1'b1; e_vs = 2'b10; end
            P_WR:   begin e_wn = ir[7:5];  e_wr = 1'b1; e_vs = 2'b00; end
            default: e_w = 1'b1;
        endcase
        return {e_w, e_rn, e_wn, e_wr, e_la, e_lb, e_lc, e_ls, e_as, e_vs,
                e_sh, e_al, e_il, {{8{ir[7]}}, ir[7:0]}};
    endfunction

    task automatic plan(input logic [15:0] ir);
        case (ir[15:11])
            5'b11010:           phases = '{P_DEC, P_WI, P_WAIT};
            5'b11000, 5'b10111: phases = '{P_DEC, P_B, P_EX, P_WR, P_WAIT};
            5'b10100, 5'b10110: phases = '{P_DEC, P_A, P_B, P_EX, P_WR, P_WAIT};
            5'b10101:           phases = '{P_DEC, P_A, P_B, P_EX, P_WAIT};
            default:            phases = '{P_DEC, P_WAIT};
        endcase
    endtask

    task automatic check(input string tag, input logic [35:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Run one instruction, optionally loading it in an earlier WAIT cycle;
    // in-flight cycles get random load/s/in that must all be ignored.
    task automatic run(input logic [15:0] instr, input bit preload);
        if (preload) begin
            in = instr; load = 1'b1; s = 1'b0;
            step();
            check($sformatf("preload %h", instr), expect_vec(P_WAIT, instr));
            load = 1'b0; s = 1'b1; in = 16'($urandom);
        end else begin
            in = instr; load = 1'b1; s = 1'b1;
        end
        plan(instr);
        for (int k = 0; k < phases.size(); k++) begin
            step();
            check($sformatf("%h cyc%0d", instr, k + 1), expect_vec(phases[k], instr));
            if (phases[k] == P_WAIT) begin
                load = 1'b0; s = 1'b0;
            end else begin
                load = 1'($urandom); s = 1'($urandom); in = 16'($urandom);
            end
        end
    endtask

    initial begin
        logic [15:0] r;
        rst_vec = {1'b1, 35'b0};
        rst_n = 1'b1; in = '0; load = 1'b0; s = 1'b0;
        #2 rst_n = 1'b0;
        #1 check("reset", rst_vec);
        step();
        step();
        check("reset held", rst_vec);
        rst_n = 1'b1;
        step();
        check("idle after reset", expect_vec(P_WAIT, 16'h0000));

        run(16'hD007, 1'b0);
        run(16'hD1FF, 1'b0);
        run(16'hA148, 1'b0);
        run(16'hA900, 1'b1);
        run(16'hE000, 1'b0);
        run(16'hC04A, 1'b0);
        run(16'hB8E3, 1'b1);
        run(16'hB6F5, 1'b0);

        // Load during GET_B is ignored, then reset lands mid-EXEC.
        in = 16'hA148; load = 1'b1; s = 1'b1;
        step(); check("rst seq dec", expect_vec(P_DEC, 16'hA148));
        load = 1'b0; s = 1'b0;
        step(); check("rst seq geta", expect_vec(P_A, 16'hA148));
        step(); check("rst seq getb", expect_vec(P_B, 16'hA148));
        in = 16'hD007; load = 1'b1; s = 1'b1;
        step(); check("rst seq exec", expect_vec(P_EX, 16'hA148));
        #2 rst_n = 1'b0;
        #1 check("mid reset", rst_vec);
        load = 1'b0; s = 1'b0;
        step(); check("mid reset held", rst_vec);
        rst_n = 1'b1;
        step(); check("ir cleared", expect_vec(P_WAIT, 16'h0000));

        for (int i = 0; i < 60; i++) begin
            r = 16'($urandom);
            case ($urandom_range(0, 3))
                0: r[15:13] = 3'b110;
                1, 2: r[15:13] = 3'b101;
                default: ;
            endcase
            run(r, 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
